// File: rtl/ahb_burst_arbiter_pkg.sv
// rtl/ahb_burst_arbiter_pkg.sv - AHB transfer/burst encodings and arbiter state type
package ahb_burst_arbiter_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FIXED = 2'd1,
    ARB_INCR  = 2'd2
  } arb_state_t;

  localparam int BEAT_CNT_W = 5;

  // Zero marks the undefined-length INCR burst.
  function automatic logic [BEAT_CNT_W-1:0] burst_beats(hburst_t hb);
    case (hb)
      HB_SINGLE:           burst_beats = 5'd1;
      HB_WRAP4, HB_INCR4:  burst_beats = 5'd4;
      HB_WRAP8, HB_INCR8:  burst_beats = 5'd8;
      HB_WRAP16, HB_INCR16: burst_beats = 5'd16;
      default:             burst_beats = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_arbiter_rr_pick.sv
// rtl/ahb_burst_arbiter_rr_pick.sv - combinational round-robin picker starting at rr_ptr
module ahb_rr_pick #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  win_onehot,
  output logic [PW-1:0] win_idx,
  output logic          any
);

  always_comb begin
    int idx;
    idx        = 0;
    win_onehot = '0;
    win_idx    = '0;
    any        = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any             = 1'b1;
        win_idx         = PW'(idx);
        win_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_burst_arbiter.sv
// rtl/ahb_burst_arbiter.sv - burst-aware round-robin arbiter for one AHB slave port
module ahb_burst_arbiter
  import ahb_burst_arbiter_pkg::*;
#(
  parameter int HMAS_NUM     = 5,
  parameter int HBURST_WIDTH = 3
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic [HMAS_NUM-1:0]     req,
  input  logic [1:0]              htrans_sel,
  input  logic [HBURST_WIDTH-1:0] hburst_sel,
  input  logic                    hready_s,
  output logic [HMAS_NUM-1:0]     grant,
  output logic [HMAS_NUM-1:0]     grant_dp,
  output logic                    locked
);

  localparam int PW = (HMAS_NUM > 1) ? $clog2(HMAS_NUM) : 1;

  arb_state_t            state, state_nx;
  logic [BEAT_CNT_W-1:0] beat_cnt, beat_nx, beats;
  logic [PW-1:0]         rr_ptr, rr_nx;
  logic [HMAS_NUM-1:0]   win_onehot;
  logic [PW-1:0]         win_idx;
  logic                  win_any;
  logic                  rearb;
  htrans_t               ht;

  assign ht    = htrans_t'(htrans_sel);
  assign beats = burst_beats(hburst_t'(hburst_sel));
  assign rr_nx = (win_idx == PW'(HMAS_NUM - 1)) ? '0 : win_idx + 1'b1;

  ahb_rr_pick #(.N(HMAS_NUM), .PW(PW)) u_pick (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .any        (win_any)
  );

  always_comb begin
    rearb    = 1'b0;
    state_nx = state;
    beat_nx  = beat_cnt;
    case (state)
      ARB_IDLE: begin
        // A SINGLE transfer needs no lock, so it re-arbitrates like an idle cycle.
        if ((|grant) && ht == HT_NONSEQ && beats != 5'd1) begin
          if (beats == 5'd0) begin
            state_nx = ARB_INCR;
          end else begin
            state_nx = ARB_FIXED;
            beat_nx  = beats - 5'd1;
          end
        end else begin
          rearb = 1'b1;
        end
      end
      ARB_FIXED: begin
        case (ht)
          HT_SEQ: begin
            if (beat_cnt == 5'd1) begin
              rearb    = 1'b1;
              state_nx = ARB_IDLE;
              beat_nx  = '0;
            end else begin
              beat_nx = beat_cnt - 5'd1;
            end
          end
          HT_BUSY: ;
          default: begin
            rearb    = 1'b1;
            state_nx = ARB_IDLE;
            beat_nx  = '0;
          end
        endcase
      end
      ARB_INCR: begin
        if (!((ht == HT_SEQ || ht == HT_BUSY) && (|(req & grant)))) begin
          rearb    = 1'b1;
          state_nx = ARB_IDLE;
        end
      end
      default: begin
        rearb    = 1'b1;
        state_nx = ARB_IDLE;
        beat_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= ARB_IDLE;
      beat_cnt <= '0;
      rr_ptr   <= '0;
      grant    <= '0;
      grant_dp <= '0;
      locked   <= 1'b0;
    end else if (hready_s) begin
      state    <= state_nx;
      beat_cnt <= beat_nx;
      locked   <= (state_nx != ARB_IDLE);
      grant_dp <= htrans_sel[1] ? grant : '0;
      if (rearb) begin
        grant <= win_any ? win_onehot : '0;
        if (win_any) rr_ptr <= rr_nx;
      end
    end
  end

endmodule

// File: tb/tb_ahb_burst_arbiter.sv
// tb/tb_ahb_burst_arbiter.sv - self-checking bench for ahb_burst_arbiter
module tb_ahb_burst_arbiter;
  localparam int N = 5;

  logic         hclk = 1'b0;
  logic         hresetn;
  logic [N-1:0] req;
  logic [1:0]   htrans_sel;
  logic [2:0]   hburst_sel;
  logic         hready_s;
  logic [N-1:0] grant, grant_dp;
  logic         locked;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: who owns the address phase, who owns the data phase,
  // and how much of the current burst is left (kind 0 none, 1 fixed, 2 incr).
  int m_owner, m_dp, m_rr, m_kind, m_left;

  always #5 hclk = ~hclk;

  ahb_burst_arbiter #(.HMAS_NUM(N), .HBURST_WIDTH(3)) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .req        (req),
    .htrans_sel (htrans_sel),
    .hburst_sel (hburst_sel),
    .hready_s   (hready_s),
    .grant      (grant),
    .grant_dp   (grant_dp),
    .locked     (locked)
  );

  function automatic logic [N-1:0] oh(int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int burst_len(logic [2:0] b);
    case (b)
      3'd0:       return 1;
      3'd1:       return 0;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  task automatic model_reset();
    m_owner = -1; m_dp = -1; m_rr = 0; m_kind = 0; m_left = 0;
  endtask

  task automatic model_accept();
    int  new_dp;
    bit  release_now;
    new_dp      = htrans_sel[1] ? m_owner : -1;
    release_now = 1'b0;
    if (m_kind == 0) begin
      if (m_owner >= 0 && htrans_sel == 2'b10 && burst_len(hburst_sel) != 1) begin
        if (burst_len(hburst_sel) == 0) m_kind = 2;
        else begin m_kind = 1; m_left = burst_len(hburst_sel) - 1; end
      end else release_now = 1'b1;
    end else if (m_kind == 1) begin
      if (htrans_sel == 2'b11) begin
        m_left--;
        if (m_left == 0) begin m_kind = 0; release_now = 1'b1; end
      end else if (htrans_sel != 2'b01) begin
        m_kind = 0; m_left = 0; release_now = 1'b1;
      end
    end else begin
      if (!(htrans_sel[0] && req[m_owner])) begin m_kind = 0; release_now = 1'b1; end
    end
    if (release_now) begin
      int found;
      found = -1;
      for (int k = 0; k < N; k++)
        if (found < 0 && req[(m_rr + k) % N]) found = (m_rr + k) % N;
      m_owner = found;
      if (found >= 0) m_rr = (found + 1) % N;
    end
    m_dp = new_dp;
  endtask

  task automatic tick();
    @(posedge hclk);
    if (hresetn && hready_s) model_accept();
    #1;
  endtask

  task automatic do_reset();
    hresetn = 1'b0; req = '0; htrans_sel = 2'b00; hburst_sel = 3'd0; hready_s = 1'b1;
    repeat (2) @(negedge hclk);
    model_reset();
    hresetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (grant !== '0 || grant_dp !== '0 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: grant=%b dp=%b locked=%b expected 0 0 0", grant, grant_dp, locked);
    end
    req = 5'b00001; tick();
    htrans_sel = 2'b10; hburst_sel = 3'd3; tick();
    htrans_sel = 2'b11; tick();
    hresetn = 1'b0;
    #2;
    n_cmp++;
    if (grant !== '0 || grant_dp !== '0 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_burst: grant=%b dp=%b locked=%b expected 0 0 0", grant, grant_dp, locked);
    end
    model_reset();
    #1;
    hresetn = 1'b1; req = 5'b00100; htrans_sel = 2'b00;
    tick();
    n_cmp++;
    if (grant !== 5'b00100) begin
      n_bad++;
      $display("FAIL reset_regrant: grant=%b expected 00100", grant);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_seq [6];
    exp_seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    do_reset();
    req = 5'b11111; htrans_sel = 2'b00; hburst_sel = 3'd0;
    for (int s = 0; s < 6; s++) begin
      tick();
      htrans_sel = 2'b10;
      n_cmp++;
      if (grant !== exp_seq[s] || grant !== oh(m_owner) || grant_dp !== oh(m_dp) || locked !== 1'b0) begin
        n_bad++;
        $display("FAIL round_robin step %0d: grant=%b dp=%b locked=%b expected %b %b 0",
                 s, grant, grant_dp, locked, exp_seq[s], oh(m_dp));
      end
    end
  endtask

  task automatic test_incr4_lock();
    logic [1:0]   tr   [6];
    logic [N-1:0] eg   [6];
    logic [N-1:0] edp  [6];
    logic         elk  [6];
    tr  = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
    eg  = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b01000, 5'b00001};
    edp = '{5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000};
    elk = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    req = 5'b01001; hburst_sel = 3'd3;
    for (int s = 0; s < 6; s++) begin
      htrans_sel = tr[s];
      tick();
      n_cmp++;
      if (grant !== eg[s] || grant_dp !== edp[s] || locked !== elk[s] ||
          grant !== oh(m_owner) || grant_dp !== oh(m_dp)) begin
        n_bad++;
        $display("FAIL incr4_lock step %0d: grant=%b dp=%b locked=%b expected %b %b %b",
                 s, grant, grant_dp, locked, eg[s], edp[s], elk[s]);
      end
    end
  endtask

  task automatic test_wait_busy();
    logic [1:0] tr [12];
    logic       hr [12];
    tr = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11};
    hr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    hburst_sel = 3'd4;
    for (int s = 0; s < 13; s++) begin
      if (s < 12) begin htrans_sel = tr[s]; hready_s = hr[s]; end
      else begin htrans_sel = 2'b11; hready_s = 1'b1; end
      req = (s >= 2 && s <= 4) ? 5'b11111 : 5'b10010;
      tick();
      n_cmp++;
      if (locked !== (s >= 1 && s <= 11) ||
          grant !== ((s <= 11) ? 5'b00010 : 5'b10000) ||
          grant !== oh(m_owner) || grant_dp !== oh(m_dp)) begin
        n_bad++;
        $display("FAIL wait_busy step %0d: grant=%b dp=%b locked=%b expected %b %b %0d",
                 s, grant, grant_dp, locked, oh(m_owner), oh(m_dp), (s >= 1 && s <= 11));
      end
    end
  endtask

  task automatic test_early_term();
    do_reset();
    req = 5'b00101; hburst_sel = 3'd7;
    for (int s = 0; s < 8; s++) begin
      htrans_sel = (s == 0 || s == 7) ? 2'b00 : ((s == 1) ? 2'b10 : 2'b11);
      tick();
      n_cmp++;
      if (grant !== ((s == 7) ? 5'b00100 : 5'b00001) || locked !== (s >= 1 && s <= 6) ||
          grant_dp !== oh(m_dp)) begin
        n_bad++;
        $display("FAIL early_term step %0d: grant=%b dp=%b locked=%b expected %b %b %0d",
                 s, grant, grant_dp, locked, oh(m_owner), oh(m_dp), (s >= 1 && s <= 6));
      end
    end
  endtask

  task automatic test_undef_incr();
    do_reset();
    req = 5'b01010; hburst_sel = 3'd1;
    htrans_sel = 2'b00; tick();
    htrans_sel = 2'b10; tick();
    for (int s = 0; s < 20; s++) begin
      htrans_sel = 2'b11; tick();
      n_cmp++;
      if (grant !== 5'b00010 || locked !== 1'b1 || grant_dp !== 5'b00010) begin
        n_bad++;
        $display("FAIL undef_incr_hold beat %0d: grant=%b dp=%b locked=%b expected 00010 00010 1",
                 s, grant, grant_dp, locked);
      end
    end
    req = 5'b01000; tick();
    n_cmp++;
    if (grant !== 5'b01000 || locked !== 1'b0 || grant !== oh(m_owner)) begin
      n_bad++;
      $display("FAIL undef_incr_drop: grant=%b locked=%b expected 01000 0", grant, locked);
    end
    req = 5'b00000; htrans_sel = 2'b00; tick();
    n_cmp++;
    if (grant !== 5'b00000 || grant_dp !== 5'b00000) begin
      n_bad++;
      $display("FAIL undef_incr_empty: grant=%b dp=%b expected 00000 00000", grant, grant_dp);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int s = 0; s < 600; s++) begin
      req        = N'($urandom_range(0, 31));
      hready_s   = ($urandom_range(0, 3) != 0);
      hburst_sel = 3'($urandom_range(0, 7));
      if (m_owner < 0)      htrans_sel = 2'b00;
      else if (m_kind == 0) htrans_sel = ($urandom_range(0, 3) != 0) ? 2'b10 : 2'b00;
      else if (m_kind == 1) htrans_sel = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 2))
                                                                     : 2'b11;
      else                  htrans_sel = 2'($urandom_range(0, 3));
      if (m_kind == 2 && $urandom_range(0, 3) != 0) req[m_owner] = 1'b1;
      tick();
      n_cmp++;
      if (grant !== oh(m_owner) || grant_dp !== oh(m_dp) || locked !== (m_kind != 0)) begin
        n_bad++;
        $display("FAIL random step %0d: grant=%b dp=%b locked=%b expected %b %b %0d",
                 s, grant, grant_dp, locked, oh(m_owner), oh(m_dp), (m_kind != 0));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_incr4_lock();
    test_wait_busy();
    test_early_term();
    test_undef_incr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
